// File: rtl/int_isq_wakeup.sv
// Integer issue queue with tag wakeup, oldest-ready select and ROB-age flush.
// Optional macro ISQ_ENQ_WAKEUP_BYPASS_EN: capture same-cycle wakeups on enqueue.
module int_isq_wakeup #(
    parameter int DEPTH       = 8,
    parameter int DATA_WIDTH  = 128,
    parameter int PREG_WIDTH  = 6,
    parameter int ROBID_WIDTH = 7,
    parameter int NUM_WB      = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             enq_valid,
    output logic                             enq_ready,
    input  logic [DATA_WIDTH-1:0]            enq_data,
    input  logic [ROBID_WIDTH-1:0]           enq_robid,
    input  logic [PREG_WIDTH-1:0]            enq_prs1,
    input  logic [PREG_WIDTH-1:0]            enq_prs2,
    input  logic                             enq_src1_rdy,
    input  logic                             enq_src2_rdy,
    output logic                             deq_valid,
    input  logic                             deq_ready,
    output logic [DATA_WIDTH-1:0]            deq_data,
    output logic [ROBID_WIDTH-1:0]           deq_robid,
    input  logic [NUM_WB-1:0]                wb_valid,
    input  logic [NUM_WB*PREG_WIDTH-1:0]     wb_prd,
    input  logic                             flush_valid,
    input  logic [ROBID_WIDTH-1:0]           flush_robid,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int MB = ROBID_WIDTH - 1;

    logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
    logic [ROBID_WIDTH-1:0] robid_q [DEPTH];
    logic [PREG_WIDTH-1:0]  prs1_q  [DEPTH];
    logic [PREG_WIDTH-1:0]  prs2_q  [DEPTH];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] s1_q, s1_d;
    logic [DEPTH-1:0] s2_q, s2_d;
    logic [DEPTH-1:0] wake1, wake2, rdy;
    logic             enq_hit1, enq_hit2;
    logic             enq_s1, enq_s2;
    logic [IW-1:0]    free_idx, sel_idx;
    logic             sel_found;
    logic             enq_fire, deq_fire;
    logic [CW-1:0]    cnt;

    // a is older than b in ROB order, honouring the wrap bit
    function automatic logic older(input logic [ROBID_WIDTH-1:0] a,
                                   input logic [ROBID_WIDTH-1:0] b);
        if (a[MB] == b[MB]) return a[MB-1:0] < b[MB-1:0];
        else                return a[MB-1:0] > b[MB-1:0];
    endfunction

    // tag match of every wakeup port against every entry and the enqueue
    always_comb begin
        wake1    = '0;
        wake2    = '0;
        enq_hit1 = 1'b0;
        enq_hit2 = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && wb_prd[k*PREG_WIDTH +: PREG_WIDTH] != '0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (prs1_q[i] == wb_prd[k*PREG_WIDTH +: PREG_WIDTH]) wake1[i] = 1'b1;
                    if (prs2_q[i] == wb_prd[k*PREG_WIDTH +: PREG_WIDTH]) wake2[i] = 1'b1;
                end
                if (enq_prs1 == wb_prd[k*PREG_WIDTH +: PREG_WIDTH]) enq_hit1 = 1'b1;
                if (enq_prs2 == wb_prd[k*PREG_WIDTH +: PREG_WIDTH]) enq_hit2 = 1'b1;
            end
        end
    end

`ifdef ISQ_ENQ_WAKEUP_BYPASS_EN
    assign enq_s1 = enq_src1_rdy | enq_hit1;
    assign enq_s2 = enq_src2_rdy | enq_hit2;
`else
    assign enq_s1 = enq_src1_rdy;
    assign enq_s2 = enq_src2_rdy;
`endif

    assign rdy = valid_q & s1_q & s2_q;

    // oldest ready entry and lowest free slot
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && (!sel_found || older(robid_q[i], robid_q[sel_idx]))) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

    // occupancy from the valid bits
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(valid_q[i]);
    end

    assign count     = cnt;
    assign enq_ready = cnt < CW'(DEPTH);
    assign deq_valid = sel_found && !flush_valid;
    assign deq_data  = data_q[sel_idx];
    assign deq_robid = robid_q[sel_idx];
    assign enq_fire  = enq_valid && enq_ready && !flush_valid;
    assign deq_fire  = deq_valid && deq_ready;

    // next valid/ready state: flush wins over enqueue and dequeue
    always_comb begin
        valid_d = valid_q;
        s1_d    = s1_q | wake1;
        s2_d    = s2_q | wake2;
        if (flush_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (older(flush_robid, robid_q[i])) valid_d[i] = 1'b0;
            end
        end else begin
            if (deq_fire) valid_d[sel_idx] = 1'b0;
            if (enq_fire) begin
                valid_d[free_idx] = 1'b1;
                s1_d[free_idx]    = enq_s1;
                s2_d[free_idx]    = enq_s2;
            end
        end
    end

    // valid bits reset asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    // payload, tags and source-ready bits need no reset
    always_ff @(posedge clock) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        if (enq_fire) begin
            data_q[free_idx]  <= enq_data;
            robid_q[free_idx] <= enq_robid;
            prs1_q[free_idx]  <= enq_prs1;
            prs2_q[free_idx]  <= enq_prs2;
        end
    end

endmodule

// File: tb/tb_int_isq_wakeup.sv
// Directed bench for int_isq_wakeup: vector table plus multi-cycle sequences.
// Expectations follow the default build unless ISQ_ENQ_WAKEUP_BYPASS_EN is set.
module tb_int_isq_wakeup;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enq_valid;
    logic         enq_ready;
    logic [127:0] enq_data;
    logic [6:0]   enq_robid;
    logic [5:0]   enq_prs1;
    logic [5:0]   enq_prs2;
    logic         enq_src1_rdy;
    logic         enq_src2_rdy;
    logic         deq_valid;
    logic         deq_ready;
    logic [127:0] deq_data;
    logic [6:0]   deq_robid;
    logic [1:0]   wb_valid;
    logic [11:0]  wb_prd;
    logic         flush_valid;
    logic [6:0]   flush_robid;
    logic [3:0]   count;

    int errors = 0;
    int checks = 0;

    int_isq_wakeup dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_data(enq_data), .enq_robid(enq_robid),
        .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
        .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_data(deq_data), .deq_robid(deq_robid),
        .wb_valid(wb_valid), .wb_prd(wb_prd),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ev;
        logic [6:0] rob;
        logic [5:0] p1;
        logic [5:0] p2;
        logic       r1;
        logic       r2;
        logic       dr;
        logic [1:0] wv;
        logic [5:0] w0;
        logic [5:0] w1;
        logic       fv;
        logic [6:0] frob;
        logic [3:0] ecnt;
        logic       erdy;
        logic       edv;
        logic [6:0] erob;
    } vec_t;

    vec_t vt [27];

    function automatic logic [127:0] mkd(input logic [6:0] r);
        return {4{~25'(r), r}};
    endfunction

    function automatic vec_t v(
        input logic ev, input logic [6:0] rob, input logic [5:0] p1,
        input logic [5:0] p2, input logic r1, input logic r2,
        input logic dr, input logic [1:0] wv, input logic [5:0] w0,
        input logic [5:0] w1, input logic fv, input logic [6:0] frob,
        input logic [3:0] ecnt, input logic edv, input logic [6:0] erob);
        vec_t t;
        t.ev = ev; t.rob = rob; t.p1 = p1; t.p2 = p2;
        t.r1 = r1; t.r2 = r2; t.dr = dr; t.wv = wv;
        t.w0 = w0; t.w1 = w1; t.fv = fv; t.frob = frob;
        t.ecnt = ecnt; t.erdy = (ecnt < 4'd8); t.edv = edv; t.erob = erob;
        return t;
    endfunction

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic drive(input logic ev, input logic [6:0] rob,
                         input logic [5:0] p1, input logic [5:0] p2,
                         input logic r1, input logic r2, input logic dr,
                         input logic [1:0] wv, input logic [5:0] w0,
                         input logic [5:0] w1, input logic fv,
                         input logic [6:0] frob);
        enq_valid    = ev;
        enq_robid    = rob;
        enq_data     = mkd(rob);
        enq_prs1     = p1;
        enq_prs2     = p2;
        enq_src1_rdy = r1;
        enq_src2_rdy = r2;
        deq_ready    = dr;
        wb_valid     = wv;
        wb_prd       = {w1, w0};
        flush_valid  = fv;
        flush_robid  = frob;
    endtask

    task automatic idle(input logic dr);
        drive(0, 0, 0, 0, 0, 0, dr, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string n, input logic [3:0] ec,
                           input logic edv, input logic [6:0] er);
        chk({n, ".count"}, 128'(count), 128'(ec));
        chk({n, ".enq_ready"}, 128'(enq_ready), 128'(ec < 4'd8));
        chk({n, ".deq_valid"}, 128'(deq_valid), 128'(edv));
        if (edv && deq_valid) begin
            chk({n, ".deq_robid"}, 128'(deq_robid), 128'(er));
            chk({n, ".deq_data"}, deq_data, mkd(er));
        end
    endtask

    initial begin
        // ev rob p1 p2 r1 r2 dr wv w0 w1 fv frob | cnt dv rob
        vt[0]  = v(1, 7'd5,  6'd12, 6'd0, 0, 1, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);
        vt[1]  = v(1, 7'd3,  6'd0,  6'd0, 1, 1, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd1, 0, 7'd0);
        vt[2]  = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd2, 1, 7'd3);
        vt[3]  = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b01, 6'd12, 6'd0, 0, 7'd0,  4'd1, 0, 7'd0);
        vt[4]  = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd1, 1, 7'd5);
        vt[5]  = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 0, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);
        vt[6]  = v(1, 7'd12, 6'd0,  6'd9, 1, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);
        vt[7]  = v(1, 7'd10, 6'd0,  6'd9, 1, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd1, 0, 7'd0);
        vt[8]  = v(1, 7'd11, 6'd0,  6'd9, 1, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd2, 0, 7'd0);
        vt[9]  = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b11, 6'd9,  6'd9, 0, 7'd0,  4'd3, 0, 7'd0);
        vt[10] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd3, 1, 7'd10);
        vt[11] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd2, 1, 7'd11);
        vt[12] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd1, 1, 7'd12);
        vt[13] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);
        vt[14] = v(1, 7'd20, 6'd0,  6'd0, 0, 1, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);
        vt[15] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b01, 6'd0,  6'd0, 0, 7'd0,  4'd1, 0, 7'd0);
        vt[16] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd1, 0, 7'd0);
        vt[17] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 1, 7'd19, 4'd1, 0, 7'd0);
        vt[18] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);
        vt[19] = v(1, 7'h7E, 6'd0,  6'd0, 1, 1, 0, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);
        vt[20] = v(1, 7'h7F, 6'd0,  6'd0, 1, 1, 0, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd1, 1, 7'h7E);
        vt[21] = v(1, 7'h01, 6'd0,  6'd0, 1, 1, 0, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd2, 1, 7'h7E);
        vt[22] = v(1, 7'h30, 6'd0,  6'd0, 1, 1, 1, 2'b00, 6'd0,  6'd0, 1, 7'h7F, 4'd3, 0, 7'd0);
        vt[23] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 0, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd2, 1, 7'h7E);
        vt[24] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd2, 1, 7'h7E);
        vt[25] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd1, 1, 7'h7F);
        vt[26] = v(0, 7'd0,  6'd0,  6'd0, 0, 0, 1, 2'b00, 6'd0,  6'd0, 0, 7'd0,  4'd0, 0, 7'd0);

        reset_n = 1'b0;
        idle(0);
        #3;
        chk_out("reset", 4'd0, 0, 7'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(vt[i].ev, vt[i].rob, vt[i].p1, vt[i].p2, vt[i].r1, vt[i].r2,
                  vt[i].dr, vt[i].wv, vt[i].w0, vt[i].w1, vt[i].fv, vt[i].frob);
            #3;
            chk(vt[i].ev ? $sformatf("v%0d.er", i) : $sformatf("v%0d.erdy", i),
                128'(enq_ready), 128'(vt[i].erdy));
            chk_out($sformatf("v%0d", i), vt[i].ecnt, vt[i].edv, vt[i].erob);
            step();
        end

        // enqueue coincident with a wakeup of its own source tag
        drive(1, 7'd40, 6'd20, 6'd0, 0, 1, 1, 2'b01, 6'd20, 6'd0, 0, 7'd0);
        #3;
        chk_out("byp0", 4'd0, 0, 7'd0);
        step();
        idle(1);
        #3;
`ifdef ISQ_ENQ_WAKEUP_BYPASS_EN
        chk_out("byp1", 4'd1, 1, 7'd40);
        step();
        #3;
        chk_out("byp2", 4'd0, 0, 7'd0);
        step();
`else
        chk_out("byp1", 4'd1, 0, 7'd0);
        step();
        step();
        #3;
        chk_out("byp2", 4'd1, 0, 7'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 2'b10, 6'd0, 6'd20, 0, 7'd0);
        #3;
        chk_out("byp3", 4'd1, 0, 7'd0);
        step();
        idle(1);
        #3;
        chk_out("byp4", 4'd1, 1, 7'd40);
        step();
        #3;
        chk_out("byp5", 4'd0, 0, 7'd0);
        step();
`endif

        // fill to capacity, then a ninth enqueue must be dropped
        for (int i = 0; i < 8; i++) begin
            drive(1, 7'(8 + i), 6'd0, 6'd0, 1, 1, 0, 2'b00, 6'd0, 6'd0, 0, 7'd0);
            #3;
            chk($sformatf("fill%0d.count", i), 128'(count), 128'(i));
            chk($sformatf("fill%0d.enq_ready", i), 128'(enq_ready), 128'(1));
            step();
        end
        drive(1, 7'd99, 6'd0, 6'd0, 1, 1, 0, 2'b00, 6'd0, 6'd0, 0, 7'd0);
        #3;
        chk_out("full", 4'd8, 1, 7'd8);
        step();
        idle(0);
        #3;
        chk_out("full2", 4'd8, 1, 7'd8);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            #3;
            chk_out($sformatf("drain%0d", i), 4'(8 - i), 1, 7'(8 + i));
            step();
        end
        idle(0);
        #3;
        chk_out("drained", 4'd0, 0, 7'd0);

        // asynchronous reset with four valid entries
        for (int i = 0; i < 4; i++) begin
            drive(1, 7'(1 + i), 6'd0, 6'd0, 1, 1, 0, 2'b00, 6'd0, 6'd0, 0, 7'd0);
            step();
        end
        idle(0);
        #1;
        chk_out("pre_rst", 4'd4, 1, 7'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 4'd0, 0, 7'd0);
        step();
        reset_n = 1'b1;
        drive(1, 7'd50, 6'd0, 6'd0, 1, 1, 0, 2'b00, 6'd0, 6'd0, 0, 7'd0);
        #3;
        chk_out("post_rst0", 4'd0, 0, 7'd0);
        step();
        idle(0);
        #3;
        chk_out("post_rst1", 4'd1, 1, 7'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
